// File: rtl/clk_ratio_mon_if.sv
// Bus bundle for clk_ratio_mon: control, monitored clocks, expectations and results.
`timescale 1ns/1ps
interface clk_ratio_mon_if #(
  parameter int unsigned CNT_W = 9
);
  logic             start;
  logic             abort;
  logic             mon_a;
  logic             mon_b;
  logic [CNT_W-1:0] exp_a;
  logic [CNT_W-1:0] exp_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail_a;
  logic             fail_b;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport master (
    output start, abort, mon_a, mon_b, exp_a, exp_b,
    input  busy, done, pass, fail_a, fail_b, cnt_a, cnt_b
  );

  modport slave (
    input  start, abort, mon_a, mon_b, exp_a, exp_b,
    output busy, done, pass, fail_a, fail_b, cnt_a, cnt_b
  );
endinterface

// File: rtl/clk_ratio_mon.sv
// Counts rising edges of two asynchronous monitored clocks over a fixed window of
// reference cycles and checks each count against a programmed expectation.
`timescale 1ns/1ps
module clk_ratio_mon #(
  parameter int unsigned WINDOW   = 256,
  parameter int unsigned CNT_W    = 9,
  parameter int unsigned TOL      = 1,
  parameter int unsigned SYNC_STG = 2
) (
  input logic            clk,
  input logic            rst_n,
  clk_ratio_mon_if.slave bus
);

  localparam int unsigned WIN_W = $clog2(WINDOW + 1);
  localparam int unsigned WRM_W = $clog2(SYNC_STG + 2);

  typedef enum logic [2:0] {IDLE, WARM, MEAS, CMP, DONE} state_t;

  state_t             state, state_nxt;
  logic               arm;
  logic [SYNC_STG-1:0] sync_a, sync_b;
  logic               hist_a, hist_b;
  logic               rise_a, rise_b;
  logic [WIN_W-1:0]   win_cnt;
  logic [WRM_W-1:0]   warm_cnt;
  logic [CNT_W-1:0]   cnt_a, cnt_b;
  logic [CNT_W-1:0]   exp_a, exp_b;
  logic               ovf_a, ovf_b;
  logic               fail_a, fail_b;
  logic               busy, done;
  logic [CNT_W:0]     diff_a, diff_b, abs_a, abs_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
      hist_a <= 1'b0;
      hist_b <= 1'b0;
    end else begin
      sync_a <= {sync_a[SYNC_STG-2:0], bus.mon_a};
      sync_b <= {sync_b[SYNC_STG-2:0], bus.mon_b};
      hist_a <= sync_a[SYNC_STG-1];
      hist_b <= sync_b[SYNC_STG-1];
    end
  end

  assign rise_a = sync_a[SYNC_STG-1] & ~hist_a;
  assign rise_b = sync_b[SYNC_STG-1] & ~hist_b;

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_nxt = WARM;
        arm       = 1'b1;
      end
      WARM: if (warm_cnt == WRM_W'(SYNC_STG)) state_nxt = MEAS;
      MEAS: if (win_cnt == WIN_W'(WINDOW - 1)) state_nxt = CMP;
      CMP:  state_nxt = DONE;
      DONE: if (bus.start) begin
        state_nxt = WARM;
        arm       = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.abort) begin
      state_nxt = IDLE;
      arm       = 1'b0;
    end
  end

  always_comb begin
    diff_a = {1'b0, cnt_a} - {1'b0, exp_a};
    diff_b = {1'b0, cnt_b} - {1'b0, exp_b};
    abs_a  = diff_a[CNT_W] ? ('0 - diff_a) : diff_a;
    abs_b  = diff_b[CNT_W] ? ('0 - diff_b) : diff_b;
  end

  // busy/done are registered from the current state, so they trail the FSM by one
  // cycle; abort and a re-arming start clear them on the same edge as the state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      warm_cnt <= '0;
      win_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      exp_a    <= '0;
      exp_b    <= '0;
      ovf_a    <= 1'b0;
      ovf_b    <= 1'b0;
      fail_a   <= 1'b0;
      fail_b   <= 1'b0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= (state == WARM) ? warm_cnt + 1'b1 : '0;
      win_cnt  <= (state == MEAS) ? win_cnt + 1'b1 : '0;
      busy     <= ~bus.abort & ((state == WARM) | (state == MEAS) | (state == CMP));
      done     <= ~bus.abort & (state == DONE) & ~bus.start;
      if (bus.abort || arm) begin
        cnt_a  <= '0;
        cnt_b  <= '0;
        ovf_a  <= 1'b0;
        ovf_b  <= 1'b0;
        fail_a <= 1'b0;
        fail_b <= 1'b0;
        if (arm) begin
          exp_a <= bus.exp_a;
          exp_b <= bus.exp_b;
        end
      end else begin
        if (state == MEAS && rise_a) begin
          if (cnt_a == '1) ovf_a <= 1'b1;
          else             cnt_a <= cnt_a + 1'b1;
        end
        if (state == MEAS && rise_b) begin
          if (cnt_b == '1) ovf_b <= 1'b1;
          else             cnt_b <= cnt_b + 1'b1;
        end
        if (state == CMP) begin
          fail_a <= ovf_a | (abs_a > (CNT_W + 1)'(TOL));
          fail_b <= ovf_b | (abs_b > (CNT_W + 1)'(TOL));
        end
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.pass   = done & ~fail_a & ~fail_b;
  assign bus.fail_a = fail_a;
  assign bus.fail_b = fail_b;
  assign bus.cnt_a  = cnt_a;
  assign bus.cnt_b  = cnt_b;

endmodule
